// File: rtl/eco32f_div_ctrl_pkg.sv
// Shared definitions for the eco32f iterative divider: the 2-bit FSM encodings and the
// operation flags captured when a divide starts.
package eco32f_div_ctrl_pkg;

  localparam logic [1:0] ECO32F_DIV_IDLE = 2'd0;
  localparam logic [1:0] ECO32F_DIV_CALC = 2'd1;
  localparam logic [1:0] ECO32F_DIV_DONE = 2'd2;

  // Sign fix-ups and result select, frozen at start so decode may move on meanwhile.
  typedef struct packed {
    logic neg_q;
    logic neg_r;
    logic op_rem;
  } div_flags_t;

endpackage

// File: rtl/eco32f_div_ctrl_if.sv
// Execute-stage <-> divider handshake: operation request, pipeline control and result.
interface eco32f_div_ctrl_if #(parameter int WIDTH = 32);

  logic             ex_flush;
  logic             ex_stall_ext;
  logic             ex_op_div;
  logic             ex_op_rem;
  logic             ex_signed_div;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             div_stall;
  logic             div_valid;
  logic [WIDTH-1:0] div_result;
  logic             div_exc_zero;

  modport master (
    output ex_flush, ex_stall_ext, ex_op_div, ex_op_rem, ex_signed_div, div_a, div_b,
    input  div_stall, div_valid, div_result, div_exc_zero
  );

  modport slave (
    input  ex_flush, ex_stall_ext, ex_op_div, ex_op_rem, ex_signed_div, div_a, div_b,
    output div_stall, div_valid, div_result, div_exc_zero
  );

endinterface

// File: rtl/eco32f_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the partial
// remainder, keep the trial subtraction only if it does not go negative.
module eco32f_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The true difference is below b whenever it is kept, so modulo-2^WIDTH arithmetic suffices.
  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = shifted >= {1'b0, b};
  assign diff    = shifted[WIDTH-1:0] - b;

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (fits) begin
      rem_next = diff;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/eco32f_div_ctrl.sv
// Iterative divide sequencer for the execute stage (DIV/DIVU/REM/REMU and immediates).
// Optional: ECO32F_DIV_EARLY_OUT_EN finishes immediately when |a| < |b|.
module eco32f_div_ctrl
  import eco32f_div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  eco32f_div_ctrl_if.slave   div_if
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  div_flags_t       flags;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             start;
  logic             early;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign abs_a = cond_neg(div_if.div_a, div_if.ex_signed_div & div_if.div_a[WIDTH-1]);
  assign abs_b = cond_neg(div_if.div_b, div_if.ex_signed_div & div_if.div_b[WIDTH-1]);
  assign start = (div_if.ex_op_div | div_if.ex_op_rem) & ~div_if.ex_flush &
                 (state == ECO32F_DIV_IDLE);

`ifdef ECO32F_DIV_EARLY_OUT_EN
  assign early = (abs_b != '0) && (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  eco32f_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .b        (b_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ECO32F_DIV_IDLE;
      count    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      flags    <= '0;
    end else if (div_if.ex_flush) begin
      state <= ECO32F_DIV_IDLE;
      exc_q <= 1'b0;
    end else begin
      case (state)
        ECO32F_DIV_IDLE: begin
          if (start) begin
            flags.neg_q  <= div_if.ex_signed_div & (div_if.div_a[WIDTH-1] ^ div_if.div_b[WIDTH-1]);
            flags.neg_r  <= div_if.ex_signed_div & div_if.div_a[WIDTH-1];
            flags.op_rem <= div_if.ex_op_rem;
            rem_q        <= '0;
            quo_q        <= abs_a;
            b_q          <= abs_b;
            count        <= CW'(WIDTH - 1);
            exc_q        <= 1'b0;
            if (div_if.div_b == '0) begin
              state    <= ECO32F_DIV_DONE;
              exc_q    <= 1'b1;
              result_q <= '0;
            end else if (early) begin
              // Quotient is zero and the remainder is the untouched dividend.
              state    <= ECO32F_DIV_DONE;
              result_q <= div_if.ex_op_rem ? div_if.div_a : '0;
            end else begin
              state <= ECO32F_DIV_CALC;
            end
          end
        end
        ECO32F_DIV_CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (count == '0) begin
            state    <= ECO32F_DIV_DONE;
            result_q <= flags.op_rem ? cond_neg(rem_next, flags.neg_r)
                                     : cond_neg(quo_next, flags.neg_q);
          end else begin
            count <= count - 1'b1;
          end
        end
        ECO32F_DIV_DONE: begin
          if (!div_if.ex_stall_ext) begin
            state <= ECO32F_DIV_IDLE;
            exc_q <= 1'b0;
          end
        end
        default: state <= ECO32F_DIV_IDLE;
      endcase
    end
  end

  assign div_if.div_stall    = start | ((state == ECO32F_DIV_CALC) & ~div_if.ex_flush);
  assign div_if.div_valid    = (state == ECO32F_DIV_DONE) & ~div_if.ex_flush;
  assign div_if.div_exc_zero = exc_q & div_if.div_valid;
  assign div_if.div_result   = result_q;

endmodule
